// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared constants and types for the register file scoreboard
package reg_file_sb_pkg;

    localparam int WORD_W = 32;
    localparam int REG_AW = 5;
    localparam int REG_N  = 32;
    localparam int SB_CW  = 2;

    typedef enum logic [1:0] {
        SB_RUN   = 2'd0,
        SB_DRAIN = 2'd1,
        SB_DONE  = 2'd2
    } sb_state_t;

endpackage

// File: rtl/reg_file_sb_counter.sv
// rtl/reg_file_sb_counter.sv - saturating pending-writer counter with error pulse
module sb_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          err
);

    localparam logic [CW-1:0] MAX = '1;

    // Overflow and underflow hold the count; the caller latches err.
    always_comb begin
        count_next = count;
        err        = 1'b0;
        if (inc && !dec) begin
            if (count == MAX) err = 1'b1;
            else              count_next = count + CW'(1);
        end else if (dec && !inc) begin
            if (count == '0) err = 1'b1;
            else             count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else     count <= count_next;
    end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with bypassed reads, pending-write scoreboard and drain FSM
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int NREG = REG_N,
    parameter int AW   = REG_AW,
    parameter int CW   = SB_CW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rs_addr,
    input  logic [AW-1:0]     rt_addr,
    output logic [WORD_W-1:0] rs_data,
    output logic [WORD_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [WORD_W-1:0] wb_data,
    input  logic              terminate,
    output logic              drained,
    output logic              sb_err
);

    logic [WORD_W-1:0] regs     [NREG];
    logic [CW-1:0]     cnt      [NREG];
    logic [CW-1:0]     cnt_next [NREG];
    logic [NREG-1:0]   cnt_err;
    logic              all_zero_next;
    logic [CW-1:0]     rs_cnt, rt_cnt;
    logic              rs_hit, rt_hit;
    sb_state_t         state, state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign cnt[0]      = '0;
    assign cnt_next[0] = '0;
    assign cnt_err[0]  = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter #(.CW(CW)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (issue_en && issue_addr == AW'(r)),
            .dec       (wb_en && wb_addr == AW'(r)),
            .count     (cnt[r]),
            .count_next(cnt_next[r]),
            .err       (cnt_err[r])
        );
    end

    always_comb begin
        all_zero_next = 1'b1;
        for (int i = 1; i < NREG; i++)
            if (cnt_next[i] != '0) all_zero_next = 1'b0;
    end

    // A writeback landing this cycle clears its own busy since the bypass supplies the value.
    always_comb begin
        rs_hit  = wb_en && wb_addr == rs_addr;
        rt_hit  = wb_en && wb_addr == rt_addr;
        rs_cnt  = cnt[rs_addr];
        rt_cnt  = cnt[rt_addr];
        rs_busy = (rs_cnt - CW'(rs_hit && rs_cnt != '0)) != '0;
        rt_busy = (rt_cnt - CW'(rt_hit && rt_cnt != '0)) != '0;
        rs_data = (rs_addr == '0) ? '0 : (rs_hit ? wb_data : regs[rs_addr]);
        rt_data = (rt_addr == '0) ? '0 : (rt_hit ? wb_data : regs[rt_addr]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SB_RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SB_RUN:   if (terminate)     state_next = SB_DRAIN;
            SB_DRAIN: if (all_zero_next) state_next = SB_DONE;
            SB_DONE:  state_next = SB_DONE;
            default:  state_next = SB_RUN;
        endcase
    end

    always_comb begin
        drained = (state == SB_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sb_err <= 1'b0;
        else if ((|cnt_err) || (issue_en && state == SB_DONE))
            sb_err <= 1'b1;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, issue_addr, wb_addr;
    logic [31:0] rs_data, rt_data, wb_data;
    logic        rs_busy, rt_busy, issue_en, wb_en, terminate, drained, sb_err;
    int          checks = 0;
    int          errors = 0;

    reg_file_sb dut (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .rs_busy   (rs_busy),
        .rt_busy   (rt_busy),
        .issue_en  (issue_en),
        .issue_addr(issue_addr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .terminate (terminate),
        .drained   (drained),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_en = 1'b0; wb_en = 1'b0; terminate = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a);
        issue_en = 1'b1; issue_addr = a;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; rs_addr = '0; rt_addr = '0; issue_addr = '0; wb_addr = '0;
        wb_data = '0; idle();
        step(); step();
        rs_addr = 5'd5;
        #1;
        check("reset_drained", {31'd0, drained}, 32'd0);
        check("reset_sb_err",  {31'd0, sb_err},  32'd0);
        check("reset_r5",      rs_data,          32'd0);
        rst = 1'b0;
        step();

        // r5 write after an issue, bypass then registered read
        issue(5'd5); step(); idle(); #1;
        check("r5_busy_issued", {31'd0, rs_busy}, 32'd1);
        wb(5'd5, 32'h0000_00AA); #1;
        check("r5_bypass", rs_data, 32'hAA);
        check("r5_bypass_busy", {31'd0, rs_busy}, 32'd0);
        step(); idle(); #1;
        check("r5_read", rs_data, 32'hAA);
        check("r5_busy", {31'd0, rs_busy}, 32'd0);
        check("r5_no_err", {31'd0, sb_err}, 32'd0);

        // writes to r0 never land
        rs_addr = 5'd0; wb(5'd0, 32'hFFFF_FFFF); #1;
        check("r0_bypass", rs_data, 32'd0);
        step(); idle(); #1;
        check("r0_read", rs_data, 32'd0);
        check("r0_busy", {31'd0, rs_busy}, 32'd0);

        // same-cycle bypass on read port B with cnt[7]=1
        rt_addr = 5'd7; issue(5'd7); step(); idle(); #1;
        check("r7_busy", {31'd0, rt_busy}, 32'd1);
        check("r7_old", rt_data, 32'd0);
        wb(5'd7, 32'h1234); #1;
        check("r7_bypass", rt_data, 32'h1234);
        check("r7_bypass_busy", {31'd0, rt_busy}, 32'd0);
        step(); idle(); #1;
        check("r7_read", rt_data, 32'h1234);

        // two issues to r3, two writebacks
        rs_addr = 5'd3; issue(5'd3); step(); step(); idle(); step(); #1;
        check("r3_busy_cnt2", {31'd0, rs_busy}, 32'd1);
        wb(5'd3, 32'h33); #1;
        check("r3_busy_wb1", {31'd0, rs_busy}, 32'd1);
        step(); idle(); #1;
        check("r3_busy_after_wb1", {31'd0, rs_busy}, 32'd1);
        wb(5'd3, 32'h44); #1;
        check("r3_busy_wb2", {31'd0, rs_busy}, 32'd0);
        check("r3_bypass_wb2", rs_data, 32'h44);
        step(); idle(); #1;
        check("r3_busy_final", {31'd0, rs_busy}, 32'd0);

        // simultaneous issue and writeback to r9 with cnt=1
        rs_addr = 5'd9; issue(5'd9); step(); idle();
        issue(5'd9); wb(5'd9, 32'h99); #1;
        check("r9_busy_same", {31'd0, rs_busy}, 32'd0);
        step(); idle(); #1;
        check("r9_busy_held", {31'd0, rs_busy}, 32'd1);
        check("r9_no_err", {31'd0, sb_err}, 32'd0);
        wb(5'd9, 32'h9A); step(); idle(); #1;
        check("r9_clear", {31'd0, rs_busy}, 32'd0);

        // terminate with r2 and r8 pending
        issue(5'd2); step(); issue(5'd8); step(); idle();
        terminate = 1'b1; step(); terminate = 1'b0; #1;
        check("drain_start", {31'd0, drained}, 32'd0);
        wb(5'd2, 32'h22); step(); idle(); #1;
        check("drain_after_wb_r2", {31'd0, drained}, 32'd0);
        wb(5'd8, 32'h88); #1;
        check("drain_before_last", {31'd0, drained}, 32'd0);
        step(); idle(); #1;
        check("drained_set", {31'd0, drained}, 32'd1);
        step(); #1;
        check("drained_hold", {31'd0, drained}, 32'd1);
        check("drain_no_err", {31'd0, sb_err}, 32'd0);

        // terminate with nothing pending passes through DRAIN
        pulse_reset();
        terminate = 1'b1; step(); terminate = 1'b0; #1;
        check("empty_term_1", {31'd0, drained}, 32'd0);
        step(); #1;
        check("empty_term_2", {31'd0, drained}, 32'd1);

        // asynchronous reset in the middle of DRAIN
        pulse_reset();
        wb(5'd8, 32'h88); issue(5'd8); step(); idle();
        issue(5'd2); terminate = 1'b1; step(); idle(); #1;
        rs_addr = 5'd2; rt_addr = 5'd8; #1;
        check("pre_rst_busy", {31'd0, rs_busy}, 32'd1);
        rst = 1'b1; #1;
        check("rst_mid_busy", {31'd0, rs_busy}, 32'd0);
        check("rst_mid_drained", {31'd0, drained}, 32'd0);
        check("rst_mid_r8", rt_data, 32'd0);
        rst = 1'b0;
        step();

        // writeback with nothing pending
        wb(5'd4, 32'h4); #1;
        check("underflow_pre", {31'd0, sb_err}, 32'd0);
        step(); idle(); #1;
        check("underflow_err", {31'd0, sb_err}, 32'd1);
        step(); step(); #1;
        check("underflow_sticky", {31'd0, sb_err}, 32'd1);

        // four issues to r6 saturate the counter
        pulse_reset();
        rs_addr = 5'd6;
        issue(5'd6); step(); step(); step(); #1;
        check("r6_cnt3_no_err", {31'd0, sb_err}, 32'd0);
        step(); idle(); #1;
        check("r6_overflow_err", {31'd0, sb_err}, 32'd1);
        wb(5'd6, 32'h6); step(); step(); idle(); #1;
        check("r6_still_busy", {31'd0, rs_busy}, 32'd1);
        wb(5'd6, 32'h66); step(); idle(); #1;
        check("r6_clear", {31'd0, rs_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
